// File: rtl/quad_encoder_decoder.sv
// Quadrature wheel-encoder decoder: A/B synchronisers, per-channel glitch filters,
// 4x decode to a wrapping 32-bit signed position, and an illegal-transition counter.
module quad_encoder_decoder #(
  parameter int FILTER_CYCLES = 4,
  parameter int ERR_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 clear,
  output logic signed [31:0]   position,
  output logic                 direction,
  output logic                 step,
  output logic                 error,
  output logic [ERR_WIDTH-1:0] err_count
);

  typedef enum logic {S_PRIME, S_RUN} state_t;

  localparam logic [7:0] FC_LAST = 8'(FILTER_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_prime_cnt;
  logic                  w_prime_load;

  // Channel vectors are packed as {A, B}
  logic [1:0]            r_sync1;
  logic [1:0]            r_sync2;
  logic [1:0]            r_filt;
  logic [1:0]            r_prev;
  logic [7:0]            r_fcnt [2];

  logic                  w_fwd;
  logic                  w_rev;
  logic                  w_illegal;

  logic signed [31:0]    r_position;
  logic                  r_direction;
  logic                  r_step;
  logic                  r_error;
  logic [ERR_WIDTH-1:0]  r_err_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_PRIME;
      r_prime_cnt <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_PRIME) r_prime_cnt <= r_prime_cnt + 2'd1;
    end
  end

  // Priming waits for the synchronisers to hold real input before seeding filter/prev
  always_comb begin
    w_state_nxt  = r_state;
    w_prime_load = 1'b0;
    case (r_state)
      S_PRIME: begin
        if (r_prime_cnt == 2'd2) begin
          w_prime_load = 1'b1;
          w_state_nxt  = S_RUN;
        end
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {enc_a, enc_b};
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_filt <= 2'b00;
      r_prev <= 2'b00;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= 8'd0;
    end else if (w_prime_load) begin
      r_filt <= r_sync2;
      r_prev <= r_sync2;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= 8'd0;
    end else if (r_state == S_RUN) begin
      r_prev <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_filt[i]) begin
          if (r_fcnt[i] == FC_LAST) begin
            r_filt[i] <= r_sync2[i];
            r_fcnt[i] <= 8'd0;
          end else begin
            r_fcnt[i] <= r_fcnt[i] + 8'd1;
          end
        end else begin
          r_fcnt[i] <= 8'd0;
        end
      end
    end
  end

  always_comb begin
    w_fwd     = 1'b0;
    w_rev     = 1'b0;
    w_illegal = 1'b0;
    if (r_state == S_RUN) begin
      case ({r_prev, r_filt})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_fwd     = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_rev     = 1'b1;
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_illegal = 1'b1;
        default: ;
      endcase
    end
  end

  // clear overrides anything decoded in the same cycle, direction included
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_position  <= 32'sd0;
      r_direction <= 1'b0;
      r_step      <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_step <= 1'b0;
      if (clear) begin
        r_position  <= 32'sd0;
        r_error     <= 1'b0;
        r_err_count <= '0;
      end else if (w_fwd) begin
        r_position  <= r_position + 32'sd1;
        r_direction <= 1'b1;
        r_step      <= 1'b1;
      end else if (w_rev) begin
        r_position  <= r_position - 32'sd1;
        r_direction <= 1'b0;
        r_step      <= 1'b1;
      end else if (w_illegal) begin
        r_error <= 1'b1;
        if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign position  = r_position;
  assign direction = r_direction;
  assign step      = r_step;
  assign error     = r_error;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Bench for quad_encoder_decoder: directed scenarios plus a random phase walk
// checked against a modulo-4 phase-index model of the encoder.
module tb_quad_encoder_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] position;
  logic        direction;
  logic        step;
  logic        error;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;
  int step_total = 0;

  // model state
  logic [31:0] m_pos;
  logic        m_dir;
  logic        m_err;
  int          m_errc;
  int          m_idx;
  int          m_steps;

  quad_encoder_decoder #(.FILTER_CYCLES(4), .ERR_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .position(position), .direction(direction), .step(step),
    .error(error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (step === 1'b1) step_total++;

  function automatic int phase_idx(input logic a, input logic b);
    case ({a, b})
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] phase_ab(input int idx);
    case (idx & 3)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input logic a, input logic b);
    @(negedge clk);
    enc_a = a;
    enc_b = b;
  endtask

  task automatic do_reset(input logic a, input logic b);
    @(negedge clk);
    reset_n = 1'b0;
    clear   = 1'b0;
    enc_a   = a;
    enc_b   = b;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(6);
  endtask

  task automatic test_reset;
    int base;
    do_reset(1'b1, 1'b1);
    base = step_total;
    wait_cyc(10);
    checks++; if (position !== 32'h0) begin errors++; $display("FAIL reset_position got=%h exp=%h", position, 32'h0); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (direction !== 1'b0) begin errors++; $display("FAIL reset_direction got=%b exp=0", direction); end
    checks++; if (step_total - base != 0) begin errors++; $display("FAIL reset_no_step got=%0d exp=0", step_total - base); end
  endtask

  task automatic test_forward;
    int base, lat;
    logic [1:0] ab;
    do_reset(1'b0, 1'b0);
    base = step_total;
    lat = 0;
    @(negedge clk);
    enc_a = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (step === 1'b1 && lat == 0) lat = k;
    end
    for (int i = 2; i <= 12; i++) begin
      ab = phase_ab(i);
      set_ab(ab[1], ab[0]);
      wait_cyc(9);
    end
    checks++; if (lat != 7) begin errors++; $display("FAIL fwd_latency got=%0d exp=7", lat); end
    checks++; if (position !== 32'd12) begin errors++; $display("FAIL fwd_position got=%0d exp=12", position); end
    checks++; if (direction !== 1'b1) begin errors++; $display("FAIL fwd_direction got=%b exp=1", direction); end
    checks++; if (step_total - base != 12) begin errors++; $display("FAIL fwd_steps got=%0d exp=12", step_total - base); end
  endtask

  task automatic test_reverse;
    int base;
    logic [1:0] ab;
    do_reset(1'b0, 1'b0);
    base = step_total;
    for (int i = 1; i <= 4; i++) begin
      ab = phase_ab(-i);
      set_ab(ab[1], ab[0]);
      wait_cyc(9);
    end
    checks++; if (position !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rev_position got=%h exp=fffffffc", position); end
    checks++; if (direction !== 1'b0) begin errors++; $display("FAIL rev_direction got=%b exp=0", direction); end
    checks++; if (step_total - base != 4) begin errors++; $display("FAIL rev_steps got=%0d exp=4", step_total - base); end
  endtask

  task automatic test_glitch;
    int base;
    logic [31:0] p0;
    p0 = position;
    base = step_total;
    set_ab(1'b1, 1'b0);
    wait_cyc(3);
    enc_a = 1'b0;
    wait_cyc(12);
    checks++; if (position !== p0) begin errors++; $display("FAIL glitch3_position got=%h exp=%h", position, p0); end
    checks++; if (step_total - base != 0) begin errors++; $display("FAIL glitch3_steps got=%0d exp=0", step_total - base); end
    set_ab(1'b1, 1'b0);
    wait_cyc(4);
    enc_a = 1'b0;
    wait_cyc(15);
    checks++; if (position !== p0) begin errors++; $display("FAIL pulse4_position got=%h exp=%h", position, p0); end
    checks++; if (step_total - base != 2) begin errors++; $display("FAIL pulse4_steps got=%0d exp=2", step_total - base); end
    checks++; if (direction !== 1'b0) begin errors++; $display("FAIL pulse4_direction got=%b exp=0", direction); end
  endtask

  task automatic test_illegal;
    int base;
    logic [31:0] p0;
    p0 = position;
    base = step_total;
    for (int i = 0; i < 300; i++) begin
      set_ab(i[0] ? 1'b0 : 1'b1, i[0] ? 1'b0 : 1'b1);
      wait_cyc(9);
    end
    wait_cyc(5);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL illegal_error got=%b exp=1", error); end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL illegal_err_count got=%0d exp=255", err_count); end
    checks++; if (position !== p0) begin errors++; $display("FAIL illegal_position got=%h exp=%h", position, p0); end
    checks++; if (step_total - base != 0) begin errors++; $display("FAIL illegal_steps got=%0d exp=0", step_total - base); end
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++; if (position !== 32'h0) begin errors++; $display("FAIL clear_position got=%h exp=0", position); end
    checks++; if (error !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL clear_error got=%b/%0d exp=0/0", error, err_count); end
  endtask

  task automatic test_random;
    int base, r, d, hold;
    logic [1:0] ab;
    do_reset(1'b0, 1'b0);
    base   = step_total;
    m_pos  = 32'h0; m_dir = 1'b0; m_err = 1'b0; m_errc = 0; m_idx = 0; m_steps = 0;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 6));
      d = (r == 0) ? 2 : (r <= 3) ? 1 : 3;
      ab = phase_ab(m_idx + d);
      hold = int'($urandom_range(9, 14));
      set_ab(ab[1], ab[0]);
      wait_cyc(hold);
      d = (phase_idx(ab[1], ab[0]) - m_idx + 4) % 4;
      if (d == 1) begin m_pos = m_pos + 32'd1; m_dir = 1'b1; m_steps++; end
      else if (d == 3) begin m_pos = m_pos - 32'd1; m_dir = 1'b0; m_steps++; end
      else if (d == 2) begin m_err = 1'b1; if (m_errc < 255) m_errc++; end
      m_idx = phase_idx(ab[1], ab[0]);
      checks++;
      if (position !== m_pos || direction !== m_dir || error !== m_err || err_count !== 8'(m_errc)) begin
        errors++;
        $display("FAIL random_move%0d got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", n,
                 position, direction, error, err_count, m_pos, m_dir, m_err, m_errc);
      end
    end
    checks++; if (step_total - base != m_steps) begin errors++; $display("FAIL random_steps got=%0d exp=%0d", step_total - base, m_steps); end
  endtask

  task automatic test_wrap_and_clear;
    int base;
    do_reset(1'b0, 1'b0);
    @(negedge clk);
    force dut.r_position = 32'h7FFF_FFFF;
    @(negedge clk);
    release dut.r_position;
    wait_cyc(2);
    checks++; if (position !== 32'h7FFF_FFFF) begin errors++; $display("FAIL preset_position got=%h exp=7fffffff", position); end
    set_ab(1'b1, 1'b0);
    wait_cyc(10);
    checks++; if (position !== 32'h8000_0000) begin errors++; $display("FAIL wrap_position got=%h exp=80000000", position); end
    checks++; if (direction !== 1'b1) begin errors++; $display("FAIL wrap_direction got=%b exp=1", direction); end
    base = step_total;
    @(negedge clk);
    enc_b = 1'b1;
    wait_cyc(6);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_cyc(10);
    checks++; if (position !== 32'h0) begin errors++; $display("FAIL clear_step_position got=%h exp=0", position); end
    checks++; if (step_total - base != 0) begin errors++; $display("FAIL clear_step_pulses got=%0d exp=0", step_total - base); end
    set_ab(1'b0, 1'b1);
    wait_cyc(10);
    checks++; if (position !== 32'h1) begin errors++; $display("FAIL after_clear_step got=%h exp=1", position); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_random();
    test_wrap_and_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
